// File: rtl/counter_johnson_pkg.sv
// Shared types and helpers for the Johnson counter and its phase decoder.
package counter_johnson_pkg;

    // Step direction of the twisted ring.
    typedef enum logic {
        JDIR_UP   = 1'b0,
        JDIR_DOWN = 1'b1
    } jdir_t;

    // Johnson code of phase index k for a ring of 'width' bits:
    // k < width gives k ones from bit 0 upward, k >= width gives ones
    // anchored at the top bit, shrinking from below.
    function automatic logic [31:0] johnson_encode(input int width, input int k);
        logic [31:0] ones;
        ones = (32'd1 << width) - 32'd1;
        if (k < width) begin
            return (32'd1 << k) - 32'd1;
        end
        return (ones << (k - width)) & ones;
    endfunction

endpackage

// File: rtl/johnson_decode.sv
// Combinational Johnson code decoder: legality, binary phase index, one-hot phase.
module johnson_decode
    import counter_johnson_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int IW    = $clog2(2 * WIDTH)
) (
    input  logic [WIDTH-1:0]   code,
    output logic               legal,
    output logic [IW-1:0]      index,
    output logic [2*WIDTH-1:0] onehot
);

    localparam int NST = 2 * WIDTH;

    // Match the code against every legal encoding; an unmatched code is
    // illegal and reports index 0 with an all-zero one-hot vector.
    always_comb begin
        legal  = 1'b0;
        index  = '0;
        onehot = '0;
        for (int k = 0; k < NST; k++) begin
            if (code == WIDTH'(johnson_encode(WIDTH, k))) begin
                legal = 1'b1;
                index = IW'(k);
            end
        end
        if (legal) begin
            onehot = {{(NST-1){1'b0}}, 1'b1} << index;
        end
    end

endmodule

// File: rtl/counter_johnson_ctrl.sv
// Up/down Johnson counter with clear, indexed load, wrap pulse, load error
// pulse and optional self-correction of illegal codes.
module counter_johnson_ctrl
    import counter_johnson_pkg::*;
#(
    parameter int WIDTH        = 4,
    parameter bit AUTO_CORRECT = 1'b1,
    localparam int IW          = $clog2(2 * WIDTH)
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_enable,
    input  logic               i_dir,
    input  logic               i_clear,
    input  logic               i_load,
    input  logic [IW-1:0]      i_load_idx,
    output logic [WIDTH-1:0]   o_counter_johnson,
    output logic [IW-1:0]      o_index,
    output logic [2*WIDTH-1:0] o_phase_onehot,
    output logic               o_wrap,
    output logic               o_illegal,
    output logic               o_load_err
);

    localparam int NST = 2 * WIDTH;

    if (WIDTH < 2) begin : g_bad_width
        $error("counter_johnson_ctrl: WIDTH must be at least 2");
    end

    logic [WIDTH-1:0] code_q;
    logic [WIDTH-1:0] code_d;
    logic             wrap_q;
    logic             wrap_d;
    logic             load_err_q;
    logic             load_err_d;
    logic             legal;
    jdir_t            dir;

    assign dir = jdir_t'(i_dir);

    johnson_decode #(
        .WIDTH (WIDTH),
        .IW    (IW)
    ) u_decode (
        .code   (code_q),
        .legal  (legal),
        .index  (o_index),
        .onehot (o_phase_onehot)
    );

    // Next-state mux: correction > clear > load > step > hold. Only a real
    // step can raise the wrap pulse; only a selected out-of-range load can
    // raise the load error pulse.
    always_comb begin
        code_d     = code_q;
        wrap_d     = 1'b0;
        load_err_d = 1'b0;
        if (!legal && AUTO_CORRECT) begin
            code_d = '0;
        end else if (i_clear) begin
            code_d = '0;
        end else if (i_load) begin
            if (int'(i_load_idx) < NST) begin
                code_d = WIDTH'(johnson_encode(WIDTH, int'(i_load_idx)));
            end else begin
                load_err_d = 1'b1;
            end
        end else if (i_enable) begin
            if (dir == JDIR_UP) begin
                code_d = {code_q[WIDTH-2:0], ~code_q[WIDTH-1]};
                wrap_d = legal && (o_index == IW'(NST - 1));
            end else begin
                code_d = {~code_q[0], code_q[WIDTH-1:1]};
                wrap_d = legal && (o_index == '0);
            end
        end
    end

    // Code register and the two single-cycle status pulses.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            code_q     <= '0;
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            code_q     <= code_d;
            wrap_q     <= wrap_d;
            load_err_q <= load_err_d;
        end
    end

    assign o_counter_johnson = code_q;
    assign o_wrap            = wrap_q;
    assign o_load_err        = load_err_q;
    assign o_illegal         = ~legal;

endmodule
